// File: rtl/vmem_arb_pkg.sv
// Shared types and widths for the video-memory arbiter slice.
// Optional posted-write buffer is enabled with VMEM_ARB_WRITE_POST_EN.
package vmem_arb_pkg;

    localparam int VMEM_ADDR_W = 14;
    localparam int VMEM_DATA_W = 12;

    // Starvation counter saturates at its all-ones value.
    localparam int WAIT_CNT_W = 10;
    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } arb_state_t;

endpackage

// File: rtl/vmem_arbiter_if.sv
// Bundles the video port, CPU bus port and RAM port of the arbiter.
// slave = arbiter side, master = video generator / CPU decoder / RAM side.
interface vmem_arbiter_if
    import vmem_arb_pkg::*;
#(
    parameter int ADDR_W = VMEM_ADDR_W,
    parameter int DATA_W = VMEM_DATA_W
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_data;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_starved;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q,
        output vid_data, cpu_ack, cpu_rdata, cpu_starved, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_q,
        input  vid_data, cpu_ack, cpu_rdata, cpu_starved, mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/vmem_arb_wait_counter.sv
// Counts cycles a CPU request is held off; raises a sticky flag once the
// count reaches MAX_WAIT. Cleared only by reset (rst low).
module vmem_arb_wait_counter
    import vmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic starved
);
    localparam logic [WAIT_CNT_W-1:0] MAX_WAIT_C = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] cnt_reg;
    logic [WAIT_CNT_W-1:0] cnt_next;
    logic                  starved_reg;

    assign cnt_next = (cnt_reg == WAIT_CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg     <= '0;
            starved_reg <= 1'b0;
        end else begin
            if (clr) begin
                cnt_reg <= '0;
            end else if (inc) begin
                cnt_reg <= cnt_next;
            end
            // Flag rises on the same edge the count reaches the threshold.
            if (inc && !clr && (cnt_next >= MAX_WAIT_C)) begin
                starved_reg <= 1'b1;
            end
        end
    end

    assign starved = starved_reg;

endmodule

// File: rtl/vmem_arbiter.sv
// Video-memory arbiter: video has absolute priority, CPU gets single
// outstanding req/ack access in free cycles. Define VMEM_ARB_WRITE_POST_EN
// to add a one-entry posted-write buffer for CPU writes.
module vmem_arbiter
    import vmem_arb_pkg::*;
#(
    parameter int ADDR_W   = VMEM_ADDR_W,
    parameter int DATA_W   = VMEM_DATA_W,
    parameter int MAX_WAIT = 300
) (
    input  logic            clk,
    input  logic            rst,
    vmem_arbiter_if.slave   bus
);
    arb_state_t        state_reg;
    arb_state_t        state_next;
    logic [DATA_W-1:0] rdata_reg;
    logic              cpu_grant;
    logic              wait_inc;
    logic              wait_clr;
    logic              starved;

`ifdef VMEM_ARB_WRITE_POST_EN
    logic              post_valid_reg;
    logic [ADDR_W-1:0] post_addr_reg;
    logic [DATA_W-1:0] post_data_reg;
    logic              post_accept;
    logic              post_drain;
`endif

    always_comb begin
        state_next = state_reg;
        cpu_grant  = 1'b0;
        wait_inc   = 1'b0;
        wait_clr   = 1'b0;
`ifdef VMEM_ARB_WRITE_POST_EN
        post_accept = 1'b0;
        // Buffer drains in any state as soon as video leaves the RAM free.
        post_drain  = rst && post_valid_reg && !bus.vid_req;
`endif
        case (state_reg)
            IDLE: begin
                if (rst && bus.cpu_req) begin
`ifdef VMEM_ARB_WRITE_POST_EN
                    if (bus.cpu_we && !post_valid_reg) begin
                        post_accept = 1'b1;
                        wait_clr    = 1'b1;
                        state_next  = ACK;
                    end else if (!bus.cpu_we && !bus.vid_req && !post_valid_reg) begin
                        // Reads wait for the buffer so they see the posted data.
                        cpu_grant  = 1'b1;
                        wait_clr   = 1'b1;
                        state_next = RD_WAIT;
                    end else begin
                        wait_inc = 1'b1;
                    end
`else
                    if (!bus.vid_req) begin
                        cpu_grant  = 1'b1;
                        wait_clr   = 1'b1;
                        state_next = bus.cpu_we ? ACK : RD_WAIT;
                    end else begin
                        wait_inc = 1'b1;
                    end
`endif
                end
            end
            RD_WAIT: state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RAM port mux; grant/drain are already gated off while rst is low.
    always_comb begin
        bus.mem_addr  = {ADDR_W{1'b0}};
        bus.mem_we    = 1'b0;
        bus.mem_wdata = bus.cpu_wdata;
        if (bus.vid_req) begin
            bus.mem_addr = bus.vid_addr;
`ifdef VMEM_ARB_WRITE_POST_EN
        end else if (post_drain) begin
            bus.mem_addr  = post_addr_reg;
            bus.mem_wdata = post_data_reg;
            bus.mem_we    = 1'b1;
`endif
        end else if (cpu_grant) begin
            bus.mem_addr = bus.cpu_addr;
            bus.mem_we   = bus.cpu_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == RD_WAIT) begin
                rdata_reg <= bus.mem_q;
            end
        end
    end

`ifdef VMEM_ARB_WRITE_POST_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            post_valid_reg <= 1'b0;
        end else if (post_accept) begin
            post_valid_reg <= 1'b1;
            post_addr_reg  <= bus.cpu_addr;
            post_data_reg  <= bus.cpu_wdata;
        end else if (post_drain) begin
            post_valid_reg <= 1'b0;
        end
    end
`endif

    vmem_arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (wait_inc),
        .clr     (wait_clr),
        .starved (starved)
    );

    assign bus.vid_data    = bus.mem_q;
    assign bus.cpu_ack     = (state_reg == ACK);
    assign bus.cpu_rdata   = rdata_reg;
    assign bus.cpu_starved = starved;

endmodule

// File: tb/tb_vmem_arbiter.sv
// Self-checking bench for vmem_arbiter: transaction-level model plus
// directed scenarios; honours VMEM_ARB_WRITE_POST_EN when defined.
module tb_vmem_arbiter;
    localparam int AW   = 14;
    localparam int DW   = 12;
    localparam int MAXW = 300;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM environment: synchronous read, read-first.
    bit [DW-1:0] ram [0:16383];
    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_q <= ram[bus.mem_addr];
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit cmp_en = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- behavioural model ----------------
    bit [DW-1:0] mmem [0:16383];
    bit          m_busy = 1'b0;
    int          m_ack_cyc = -1;
    bit          m_ack_rd = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    int          m_wc = 0;
    bit          m_starved = 1'b0;
    bit          m_pv = 1'b0;
    logic [AW-1:0] m_pa = '0;
    logic [DW-1:0] m_pd = '0;
    bit          m_vv = 1'b0;
    logic [DW-1:0] m_vd = '0;

    task automatic accept_txn(input bit is_rd, input int lat, input logic [DW-1:0] rd);
        m_busy    = 1'b1;
        m_ack_cyc = cyc + lat;
        m_ack_rd  = is_rd;
        m_rdata   = rd;
        m_wc      = 0;
    endtask

    task automatic model_step();
        bit pv_old;
        bit blocked;
        pv_old  = m_pv;
        blocked = 1'b0;
        m_vv = bus.vid_req;
        if (bus.vid_req) m_vd = mmem[bus.vid_addr];
        if (!rst) begin
            m_busy = 1'b0; m_wc = 0; m_starved = 1'b0; m_pv = 1'b0;
            return;
        end
        if (pv_old && !bus.vid_req) begin
            mmem[m_pa] = m_pd;
            m_pv = 1'b0;
        end
        if (m_busy) begin
            if (cyc == m_ack_cyc) m_busy = 1'b0;
        end else if (bus.cpu_req) begin
`ifdef VMEM_ARB_WRITE_POST_EN
            if (bus.cpu_we && !pv_old) begin
                m_pv = 1'b1; m_pa = bus.cpu_addr; m_pd = bus.cpu_wdata;
                accept_txn(1'b0, 1, '0);
            end else if (!bus.cpu_we && !bus.vid_req && !pv_old) begin
                accept_txn(1'b1, 2, mmem[bus.cpu_addr]);
            end else begin
                blocked = 1'b1;
            end
`else
            if (!bus.vid_req) begin
                if (bus.cpu_we) begin
                    mmem[bus.cpu_addr] = bus.cpu_wdata;
                    accept_txn(1'b0, 1, '0);
                end else begin
                    accept_txn(1'b1, 2, mmem[bus.cpu_addr]);
                end
            end else begin
                blocked = 1'b1;
            end
`endif
        end
        if (blocked) begin
            m_wc = (m_wc >= 1023) ? 1023 : m_wc + 1;
            if (m_wc >= MAXW) m_starved = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
        cyc++;
    end

    // ---------------- per-cycle comparison ----------------
    task automatic compare();
        bit drain;
        bit grant;
        bit exp_ack;
`ifdef VMEM_ARB_WRITE_POST_EN
        drain = rst && m_pv && !bus.vid_req;
        grant = rst && !m_busy && bus.cpu_req && !bus.cpu_we && !bus.vid_req && !m_pv;
`else
        drain = 1'b0;
        grant = rst && !m_busy && bus.cpu_req && !bus.vid_req;
`endif
        if (bus.vid_req) begin
            chk("vid_mem_addr", 32'(bus.mem_addr), 32'(bus.vid_addr));
            chk("vid_mem_we", 32'(bus.mem_we), 32'd0);
        end else if (drain) begin
            chk("drain_mem_addr", 32'(bus.mem_addr), 32'(m_pa));
            chk("drain_mem_wdata", 32'(bus.mem_wdata), 32'(m_pd));
            chk("drain_mem_we", 32'(bus.mem_we), 32'd1);
        end else if (grant) begin
            chk("cpu_mem_addr", 32'(bus.mem_addr), 32'(bus.cpu_addr));
            chk("cpu_mem_we", 32'(bus.mem_we), 32'(bus.cpu_we));
            if (bus.cpu_we) chk("cpu_mem_wdata", 32'(bus.mem_wdata), 32'(bus.cpu_wdata));
        end else begin
            chk("free_mem_addr", 32'(bus.mem_addr), 32'd0);
            chk("free_mem_we", 32'(bus.mem_we), 32'd0);
        end
        exp_ack = m_busy && (cyc == m_ack_cyc);
        chk("cpu_ack", 32'(bus.cpu_ack), 32'(exp_ack));
        if (exp_ack && m_ack_rd) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_rdata));
        chk("cpu_starved", 32'(bus.cpu_starved), 32'(m_starved));
        if (m_vv) chk("vid_data", 32'(bus.vid_data), 32'(m_vd));
    endtask

    initial forever begin
        @(negedge clk);
        if (cmp_en) compare();
    end

    // Observation helpers for the directed checks.
    int ack_cnt = 0;
    int last_ack_cyc = -1;
    int st_cyc = -1;
    int peak = 0;
    initial forever begin
        @(negedge clk);
        if (bus.cpu_ack === 1'b1) begin
            ack_cnt++;
            last_ack_cyc = cyc;
        end
        if (bus.cpu_starved === 1'b1 && st_cyc < 0) st_cyc = cyc;
        if (int'(dut.u_wait_cnt.cnt_reg) > peak) peak = int'(dut.u_wait_cnt.cnt_reg);
    end

    // ---------------- stimulus tasks ----------------
    task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat, output logic [DW-1:0] q,
                          output logic [AW-1:0] addr_t, output logic we_t);
        int start;
        lat = -1; q = '0; addr_t = '0; we_t = 1'b0;
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        start = cyc;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 0) begin
                addr_t = bus.mem_addr;
                we_t   = bus.mem_we;
            end
            if (bus.cpu_ack === 1'b1) begin
                lat = cyc - start;
                q   = bus.cpu_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        $display("txn %s addr=0x%04h data=0x%03h latency=%0d", we ? "WR" : "RD", a, we ? d : q, lat);
    endtask

    task automatic vid_burst(input int len, input logic [AW-1:0] base);
        @(posedge clk); #1;
        bus.vid_req = 1'b1; bus.vid_addr = base;
        repeat (len - 1) begin
            @(posedge clk); #1;
            bus.vid_addr = bus.vid_addr + 1'b1;
        end
        @(posedge clk); #1;
        bus.vid_req = 1'b0; bus.vid_addr = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int lat, lat2, wstart;
        logic [DW-1:0] q, q2;
        logic [AW-1:0] at;
        logic wt;

        bus.vid_req = 1'b0; bus.vid_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ack", 32'(bus.cpu_ack), 32'd0);
        chk("reset_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("reset_starved", 32'(bus.cpu_starved), 32'd0);
        chk("reset_mem_we", 32'(bus.mem_we), 32'd0);
        cmp_en = 1'b1;
        @(posedge clk); #1 rst = 1'b1;

        // Preload 0x0123 = 0xABC.
        cpu_op(1'b1, 14'h0123, 12'hABC, lat, q, at, wt);
        chk("preload_lat", 32'(lat), 32'd1);

        // Idle-video read.
        cpu_op(1'b0, 14'h0123, 12'h000, lat, q, at, wt);
        chk("rd_addr_T", 32'(at), 32'h0123);
        chk("rd_lat", 32'(lat), 32'd2);
        chk("rd_data", 32'(q), 32'hABC);

        // Idle-video write and readback.
        cpu_op(1'b1, 14'h3040, 12'h5A5, lat, q, at, wt);
        chk("wr_we_T", 32'(wt), 32'd1);
        chk("wr_lat", 32'(lat), 32'd1);
        cpu_op(1'b0, 14'h3040, 12'h000, lat, q, at, wt);
        chk("wr_readback", 32'(q), 32'h5A5);

        // 258-cycle video burst, CPU read raised two cycles in.
        peak = 0;
        fork
            vid_burst(258, 14'h0100);
            begin
                repeat (2) @(posedge clk);
                cpu_op(1'b0, 14'h3040, 12'h000, lat, q, at, wt);
            end
        join
        chk("burst_lat", 32'(lat), 32'd258);
        chk("burst_data", 32'(q), 32'h5A5);
        chk("burst_peak_wait", 32'(peak), 32'd256);
        chk("burst_not_starved", 32'(bus.cpu_starved), 32'd0);

        // 400-cycle burst, CPU raised in the same cycle video rises.
        peak = 0; st_cyc = -1;
        fork
            vid_burst(400, 14'h0000);
            cpu_op(1'b0, 14'h0123, 12'h000, lat, q, at, wt);
        join
        chk("starve_lat", 32'(lat), 32'd402);
        chk("starve_data", 32'(q), 32'hABC);
        chk("starve_rise_to_ack", 32'(last_ack_cyc - st_cyc), 32'd102);
        chk("starve_peak_wait", 32'(peak), 32'd400);
        cpu_op(1'b0, 14'h3040, 12'h000, lat, q, at, wt);
        chk("starve_sticky", 32'(bus.cpu_starved), 32'd1);

        // Reset during RD_WAIT abandons the access.
        ack_cnt = 0;
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0123;
        @(posedge clk); #1;
        rst = 1'b0; bus.cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rdwait_ack", 32'(bus.cpu_ack), 32'd0);
        chk("rst_rdwait_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rst_rdwait_starved", 32'(bus.cpu_starved), 32'd0);
        repeat (4) @(negedge clk);
        chk("rst_rdwait_no_ack", 32'(ack_cnt), 32'd0);
        cpu_op(1'b0, 14'h3040, 12'h000, lat, q, at, wt);
        chk("post_rst_lat", 32'(lat), 32'd2);
        chk("post_rst_data", 32'(q), 32'h5A5);

        // Request withdrawn before grant: nothing issued.
        ack_cnt = 0;
        fork
            vid_burst(10, 14'h2000);
            begin
                @(posedge clk); #1;
                bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0123;
                repeat (3) @(posedge clk);
                #1 bus.cpu_req = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        chk("withdraw_no_ack", 32'(ack_cnt), 32'd0);

        // Request dropped right after grant still completes.
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0123;
        wstart = cyc;
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        lat2 = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.cpu_ack === 1'b1 && lat2 < 0) begin
                lat2 = cyc - wstart;
                q2   = bus.cpu_rdata;
            end
        end
        chk("drop_after_grant_lat", 32'(lat2), 32'd2);
        chk("drop_after_grant_data", 32'(q2), 32'hABC);

        // CPU write then read of the same word during a video burst.
        fork
            vid_burst(20, 14'h0400);
            begin
                repeat (2) @(posedge clk);
                cpu_op(1'b1, 14'h0007, 12'h111, lat, q, at, wt);
                cpu_op(1'b0, 14'h0007, 12'h000, lat2, q2, at, wt);
            end
        join
`ifdef VMEM_ARB_WRITE_POST_EN
        chk("vidwr_lat", 32'(lat), 32'd1);
        chk("vidrd_lat", 32'(lat2), 32'd18);
`else
        chk("vidwr_lat", 32'(lat), 32'd19);
        chk("vidrd_lat", 32'(lat2), 32'd2);
`endif
        chk("vidrd_data", 32'(q2), 32'h111);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vmem_arbiter.md
Name: vmem_arbiter

Overview:
- Shares the single-port, synchronous-read video memory (14-bit address, 12-bit data) between the video generator and the CPU bus.
- The video generator has absolute priority: it fetches on even scanlines for about 258 consecutive cycles and cannot tolerate stalls.
- The CPU gets single-outstanding req/ack access in every cycle the video side leaves free.
- Sits between the video generator's vmem port, the CPU memory decoder and the vmem RAM instance.

Parameters:
- ADDR_W, 14, vmem address width.
- DATA_W, 12, vmem word width.
- MAX_WAIT, 300, number of CPU wait cycles after which the starvation flag sets. Valid range 1..1023.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- vid_req  in  1  video generator owns the memory this cycle.
- vid_addr  in  ADDR_W  video fetch address.
- vid_data  out  DATA_W  read data; wired directly to mem_q.
- cpu_req  in  1  CPU request; held with cmd/addr/wdata stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  registered read data; valid while cpu_ack is high.
- cpu_starved  out  1  sticky starvation flag.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_q  in  DATA_W  RAM read data, valid the cycle after its address.

Behaviour:
- Reset (rst low at a clk edge):
  - FSM goes to IDLE.
  - cpu_ack=0, cpu_rdata=0, cpu_starved=0, wait_cnt=0.
  - Any in-flight CPU access is abandoned with no ack.
  - mem_we is forced to 0 during reset.
- Memory mux (combinational):
  - When vid_req=1: mem_addr=vid_addr and mem_we=0, in every state.
  - Otherwise, in a CPU grant cycle: mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.
  - Otherwise: mem_addr=0, mem_we=0.
  - mem_wdata is don't-care when not writing; drive cpu_wdata.
- FSM states: IDLE, RD_WAIT, ACK.
- IDLE:
  - Grant occurs when cpu_req=1 and vid_req=0.
  - Read grant goes to RD_WAIT; write grant (RAM written this cycle) goes to ACK.
  - When cpu_req=1 and vid_req=1: no grant, stay in IDLE.
- RD_WAIT:
  - Capture cpu_rdata <= mem_q at the end of the cycle, then go to ACK.
  - vid_req may be high in this cycle; the capture is unaffected.
- ACK:
  - cpu_ack=1 for exactly one cycle, then go to IDLE.
  - cpu_req is not sampled in ACK.
  - A requester wanting back-to-back access presents its next command in the cycle after ack.
- Latency with no video contention:
  - Read: grant at T, cpu_ack and cpu_rdata at T+2.
  - Write: grant at T, cpu_ack at T+1.
  - Each cycle of vid_req=1 while a request is pending adds one cycle.
- Video latency: vid_addr at T gives vid_data at T+1; the arbiter adds zero cycles on the video path.
- Starvation counter (wait_cnt, 10 bits):
  - Increments in IDLE when cpu_req=1 and vid_req=1; saturates at 1023.
  - Clears on grant.
  - cpu_starved sets when wait_cnt reaches MAX_WAIT and stays set until reset.
- Boundary cases:
  - vid_req rising in the same cycle as cpu_req: video wins.
  - cpu_req dropped before grant: the request is withdrawn, nothing is issued.
  - cpu_req dropped after grant: the access still completes and acks.

Optional Feature:
- VMEM_ARB_WRITE_POST_EN
- Defined:
  - A one-entry posted-write buffer (addr, data, valid) is added.
  - In IDLE, cpu_req=1 with cpu_we=1 and the buffer empty: capture the write into the buffer and go to ACK regardless of vid_req, so cpu_ack comes at T+1 even during video fetch.
  - The buffer drains to RAM in the first cycle with vid_req=0, taking priority over any new CPU grant.
  - A CPU read, or a write arriving while the buffer is full, waits until the buffer drains. This guarantees read-after-write ordering.
  - Reset clears the buffer valid bit; the buffered write is lost.
- Undefined:
  - Writes wait for a free slot exactly as reads do.

Decomposition:
- Package vmem_arb_pkg holds:
  - the FSM state enum (IDLE, RD_WAIT, ACK);
  - VMEM_ADDR_W=14 and VMEM_DATA_W=12;
  - the width of the wait counter.
- Sub-module vmem_arb_wait_counter (saturating counter plus sticky flag) is natural; the mux and FSM stay in the top level.

Test Plan:
- Idle video, CPU read of 0x0123 (RAM holds 0xABC) -> mem_addr=0x0123 at T; cpu_ack and cpu_rdata=0xABC at T+2.
- Idle video, CPU write 0x5A5 to 0x3040 -> mem_we=1 at T; cpu_ack at T+1; readback returns 0x5A5.
- vid_req high for cycles 10..267, cpu_req read raised at cycle 12 -> mem_addr follows vid_addr throughout; grant at 268, ack at 270; wait_cnt peaks at 256; cpu_starved stays 0.
- vid_req held high for 400 cycles with cpu_req pending -> cpu_starved goes to 1 at wait cycle 300 and stays set after the grant until rst=0.
- rst asserted in RD_WAIT -> no cpu_ack; outputs return to reset values the next cycle; a fresh read completes normally.
- With VMEM_ARB_WRITE_POST_EN, vid_req high, CPU write 0x111 to 0x0007 followed by a read of 0x0007 -> write acks at T+1; the read returns 0x111 after vid_req drops.
